// File: rtl/pcm_capture_ctrl.sv
// pcm_capture_ctrl: packs 16-bit PCM samples into a byte FIFO (low byte first, pairs never split)
// and hands one FIFO byte, fill byte or drop-count byte to the SPI slave per busy rise.
module pcm_capture_ctrl #(
  parameter logic [7:0]  FILL_BYTE = 8'h00,
  parameter int unsigned DROP_W    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pcm_data,
  input  logic        pcm_ready,
  input  logic [7:0]  cmd_byte,
  input  logic        cmd_valid,
  input  logic        spi_busy,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  output logic        fifo_wr_en,
  output logic [7:0]  fifo_wr_data,
  input  logic        fifo_full,
  output logic        fifo_rd_en,
  input  logic [7:0]  fifo_rd_data,
  input  logic        fifo_empty,
  output logic        capturing,
  output logic        overflow
);

  localparam logic [7:0] CMD_START = 8'h01;
  localparam logic [7:0] CMD_STOP  = 8'h02;
  localparam logic [7:0] CMD_CLEAR = 8'h03;
  localparam logic [7:0] CMD_RDROP = 8'h04;

  // W_IDLE: waiting for a sample | W_HIGH: low byte written, high byte pending
  typedef enum logic {W_IDLE, W_HIGH} w_state_t;
  // R_IDLE: waiting for busy rise | R_POP: FIFO read issued | R_LOAD: FIFO data valid
  typedef enum logic [1:0] {R_IDLE, R_POP, R_LOAD} r_state_t;

  w_state_t          w_state, w_next;
  r_state_t          r_state, r_next;
  logic              wr_lo, wr_hi, drop;
  logic              pop, load_fill, load_rpt, load_fifo;
  logic [7:0]        sample_hi;
  logic [DROP_W-1:0] drop_cnt;
  logic [15:0]       cnt16;
  logic              rpt_armed, rpt_phase;
  logic [7:0]        rpt_hi;
  logic              busy_s1, busy_s2, busy_hist, busy_rise;
  logic              cmd_start, cmd_stop, cmd_clear, cmd_rdrop;

  assign cmd_start = cmd_valid && (cmd_byte == CMD_START);
  assign cmd_stop  = cmd_valid && (cmd_byte == CMD_STOP);
  assign cmd_clear = cmd_valid && (cmd_byte == CMD_CLEAR);
  assign cmd_rdrop = cmd_valid && (cmd_byte == CMD_RDROP);
  assign busy_rise = busy_s2 && !busy_hist;
  assign cnt16     = 16'(drop_cnt);

  always_comb begin
    w_next = w_state;
    wr_lo  = 1'b0;
    wr_hi  = 1'b0;
    drop   = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (pcm_ready && capturing) begin
          if (!fifo_full) begin
            wr_lo  = 1'b1;
            w_next = W_HIGH;
          end else begin
            drop = 1'b1;
          end
        end
      end
      W_HIGH: begin
        drop = pcm_ready;
        if (!fifo_full) begin
          wr_hi  = 1'b1;
          w_next = W_IDLE;
        end
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next    = r_state;
    pop       = 1'b0;
    load_fill = 1'b0;
    load_rpt  = 1'b0;
    load_fifo = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (busy_rise) begin
          if (rpt_armed)       load_rpt  = 1'b1;
          else if (fifo_empty) load_fill = 1'b1;
          else begin
            pop    = 1'b1;
            r_next = R_POP;
          end
        end
      end
      R_POP:   r_next = R_LOAD;
      R_LOAD: begin
        load_fifo = 1'b1;
        r_next    = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state      <= W_IDLE;
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= 8'h00;
      sample_hi    <= 8'h00;
      capturing    <= 1'b0;
      overflow     <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      w_state    <= w_next;
      fifo_wr_en <= wr_lo || wr_hi;
      if (wr_lo) begin
        sample_hi    <= pcm_data[15:8];
        fifo_wr_data <= pcm_data[7:0];
      end else if (wr_hi) begin
        fifo_wr_data <= sample_hi;
      end
      if (cmd_start)     capturing <= 1'b1;
      else if (cmd_stop) capturing <= 1'b0;
      // a clear in the same cycle as a drop wins
      if (cmd_start || cmd_clear) begin
        drop_cnt <= '0;
        overflow <= 1'b0;
      end else if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= R_IDLE;
      busy_s1    <= 1'b0;
      busy_s2    <= 1'b0;
      busy_hist  <= 1'b0;
      fifo_rd_en <= 1'b0;
      tx_valid   <= 1'b0;
      tx_byte    <= 8'h00;
      rpt_armed  <= 1'b0;
      rpt_phase  <= 1'b0;
      rpt_hi     <= 8'h00;
    end else begin
      busy_s1    <= spi_busy;
      busy_s2    <= busy_s1;
      busy_hist  <= busy_s2;
      r_state    <= r_next;
      fifo_rd_en <= pop;
      tx_valid   <= load_fill || load_rpt || load_fifo;
      if (load_fifo)      tx_byte <= fifo_rd_data;
      else if (load_fill) tx_byte <= FILL_BYTE;
      else if (load_rpt)  tx_byte <= rpt_phase ? rpt_hi : cnt16[7:0];
      // high byte is snapshotted with the low byte so the pair is consistent
      if (load_rpt) begin
        if (!rpt_phase) begin
          rpt_hi    <= cnt16[15:8];
          rpt_phase <= 1'b1;
        end else begin
          rpt_armed <= 1'b0;
          rpt_phase <= 1'b0;
        end
      end
      if (cmd_rdrop) begin
        rpt_armed <= 1'b1;
        rpt_phase <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pcm_capture_ctrl.sv
// Testbench for pcm_capture_ctrl: FIFO behavioural model, vector table,
// corner-case sequences and randomized traffic against a byte-queue reference.
module tb_pcm_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pcm_data;
  logic        pcm_ready;
  logic [7:0]  cmd_byte;
  logic        cmd_valid;
  logic        spi_busy;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        fifo_wr_en;
  logic [7:0]  fifo_wr_data;
  logic        fifo_full;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rd_data;
  logic        fifo_empty;
  logic        capturing;
  logic        overflow;

  logic        force_full;
  logic [7:0]  fq[$];
  int          fifo_n;
  logic [7:0]  exp_stream[$];
  int          total = 0;
  int          bad = 0;

  localparam logic [7:0] FILL = 8'h00;

  pcm_capture_ctrl #(.FILL_BYTE(FILL), .DROP_W(9)) dut (
    .clk(clk), .rst_n(rst_n), .pcm_data(pcm_data), .pcm_ready(pcm_ready),
    .cmd_byte(cmd_byte), .cmd_valid(cmd_valid), .spi_busy(spi_busy),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data), .fifo_full(fifo_full), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
    .capturing(capturing), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // 16-deep byte FIFO, read data registered one cycle after rd_en
  assign fifo_empty = (fifo_n == 0);
  assign fifo_full  = force_full || (fifo_n >= 16);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete();
      fifo_n       <= 0;
      fifo_rd_data <= 8'h00;
    end else begin
      if (fifo_rd_en && fq.size() > 0) fifo_rd_data <= fq.pop_front();
      if (fifo_wr_en) fq.push_back(fifo_wr_data);
      fifo_n <= fq.size();
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic send_cmd(input logic [7:0] c);
    cmd_byte  = c;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  // called in cycle P+1; checks the pair (or absence of writes) through P+3
  task automatic check_pair(input logic [15:0] d, input bit exp_wr);
    if (exp_wr) begin
      chk("wr_lo_en", fifo_wr_en, 1);
      chk("wr_lo_data", fifo_wr_data, d[7:0]);
      tick();
      chk("wr_hi_en", fifo_wr_en, 1);
      chk("wr_hi_data", fifo_wr_data, d[15:8]);
      exp_stream.push_back(d[7:0]);
      exp_stream.push_back(d[15:8]);
    end else begin
      chk("no_wr_p1", fifo_wr_en, 0);
      tick();
      chk("no_wr_p2", fifo_wr_en, 0);
    end
    tick();
    chk("no_third_wr", fifo_wr_en, 0);
  endtask

  task automatic do_sample(input logic [15:0] d, input bit exp_wr);
    pcm_data  = d;
    pcm_ready = 1'b1;
    tick();
    pcm_ready = 1'b0;
    check_pair(d, exp_wr);
  endtask

  task automatic do_read(input bit pop, input logic [7:0] exp);
    spi_busy = 1'b1;
    tick();
    tick();
    tick();
    if (pop) begin
      chk("rd_en_e1", fifo_rd_en, 1);
      chk("tx_valid_e1_pop", tx_valid, 0);
      tick();
      chk("rd_en_e2", fifo_rd_en, 0);
      tick();
      chk("tx_valid_e3", tx_valid, 1);
      chk("tx_byte_e3", tx_byte, exp);
    end else begin
      chk("tx_valid_e1", tx_valid, 1);
      chk("tx_byte_e1", tx_byte, exp);
      chk("rd_en_none", fifo_rd_en, 0);
    end
    tick();
    chk("tx_valid_pulse", tx_valid, 0);
    chk("tx_byte_hold", tx_byte, exp);
    chk("rd_en_after", fifo_rd_en, 0);
    spi_busy = 1'b0;
    repeat (3) tick();
  endtask

  task automatic read_next();
    if (exp_stream.size() > 0) do_read(1'b1, exp_stream.pop_front());
    else do_read(1'b0, FILL);
  endtask

  task automatic drain();
    while (exp_stream.size() > 0) read_next();
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_tx_byte"}, tx_byte, 0);
    chk({tag, "_tx_valid"}, tx_valid, 0);
    chk({tag, "_wr_en"}, fifo_wr_en, 0);
    chk({tag, "_wr_data"}, fifo_wr_data, 0);
    chk({tag, "_rd_en"}, fifo_rd_en, 0);
    chk({tag, "_capturing"}, capturing, 0);
    chk({tag, "_overflow"}, overflow, 0);
  endtask

  typedef struct {
    logic        cmd_en;
    logic [7:0]  cmd;
    logic        rdy;
    logic [15:0] data;
    logic        exp_wr;
    logic        exp_cap;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{1'b0, 8'h00, 1'b1, 16'h1111, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'h01, 1'b1, 16'h2222, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 16'h3344, 1'b1, 1'b1};
    vecs[3]  = '{1'b1, 8'h07, 1'b1, 16'h5566, 1'b1, 1'b1};
    vecs[4]  = '{1'b1, 8'h02, 1'b1, 16'h7788, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 16'h99AA, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 8'h03, 1'b1, 16'hBBCC, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 8'h01, 1'b0, 16'h0000, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 8'h00, 1'b1, 16'hDDEE, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 8'h03, 1'b1, 16'hF00D, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 8'h02, 1'b0, 16'h0000, 1'b0, 1'b0};

    rst_n = 1'b0; pcm_data = 16'h0; pcm_ready = 1'b0; cmd_byte = 8'h0;
    cmd_valid = 1'b0; spi_busy = 1'b0; force_full = 1'b0;
    repeat (3) tick();
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (2) tick();

    // empty FIFO read yields the fill byte without a pop
    do_read(1'b0, FILL);

    // two samples spaced 200 cycles, then four readouts
    send_cmd(8'h01);
    chk("start_capturing", capturing, 1);
    do_sample(16'h1234, 1'b1);
    repeat (200) tick();
    do_sample(16'hBEEF, 1'b1);
    repeat (4) read_next();

    // simultaneous command / sample vectors
    send_cmd(8'h02);
    chk("stop_capturing", capturing, 0);
    foreach (vecs[i]) begin
      cmd_valid = vecs[i].cmd_en;
      cmd_byte  = vecs[i].cmd;
      pcm_ready = vecs[i].rdy;
      pcm_data  = vecs[i].data;
      tick();
      cmd_valid = 1'b0;
      pcm_ready = 1'b0;
      chk($sformatf("vec%0d_capturing", i), capturing, vecs[i].exp_cap);
      check_pair(vecs[i].data, vecs[i].exp_wr);
    end
    drain();

    // drops while full, drop report, report restart, clear
    send_cmd(8'h01);
    force_full = 1'b1;
    repeat (3) do_sample(16'hCAFE, 1'b0);
    chk("overflow_set", overflow, 1);
    force_full = 1'b0;
    send_cmd(8'h04);
    do_read(1'b0, 8'h03);
    do_read(1'b0, 8'h00);
    send_cmd(8'h04);
    do_read(1'b0, 8'h03);
    send_cmd(8'h04);
    do_read(1'b0, 8'h03);
    do_read(1'b0, 8'h00);
    do_read(1'b0, FILL);
    chk("overflow_still", overflow, 1);
    send_cmd(8'h03);
    chk("overflow_cleared", overflow, 0);
    send_cmd(8'h04);
    do_read(1'b0, 8'h00);
    do_read(1'b0, 8'h00);

    // clear and a drop in the same cycle: clear wins
    force_full = 1'b1;
    do_sample(16'h0101, 1'b0);
    chk("overflow_pre_clr", overflow, 1);
    pcm_ready = 1'b1; cmd_byte = 8'h03; cmd_valid = 1'b1;
    tick();
    pcm_ready = 1'b0; cmd_valid = 1'b0;
    chk("clear_wins_overflow", overflow, 0);
    force_full = 1'b0;
    send_cmd(8'h04);
    do_read(1'b0, 8'h00);
    do_read(1'b0, 8'h00);

    // high byte stalls on full, one sample dropped meanwhile
    begin
      int wr_seen;
      pcm_data = 16'hA55A; pcm_ready = 1'b1;
      tick();
      pcm_ready = 1'b0; force_full = 1'b1;
      chk("stall_lo_en", fifo_wr_en, 1);
      chk("stall_lo_data", fifo_wr_data, 8'h5A);
      wr_seen = 0;
      for (int i = 0; i < 50; i++) begin
        pcm_ready = (i == 20);
        pcm_data  = 16'hFFFF;
        tick();
        if (fifo_wr_en) wr_seen++;
      end
      pcm_ready = 1'b0; force_full = 1'b0;
      chk("stall_no_wr", wr_seen, 0);
      tick();
      chk("stall_hi_en", fifo_wr_en, 1);
      chk("stall_hi_data", fifo_wr_data, 8'hA5);
      wr_seen = 0;
      repeat (5) begin
        tick();
        if (fifo_wr_en) wr_seen++;
      end
      chk("stall_no_third", wr_seen, 0);
      chk("stall_overflow", overflow, 1);
      exp_stream.push_back(8'h5A);
      exp_stream.push_back(8'hA5);
    end
    send_cmd(8'h04);
    do_read(1'b0, 8'h01);
    do_read(1'b0, 8'h00);
    drain();

    // saturation of the 9-bit drop counter
    send_cmd(8'h01);
    force_full = 1'b1;
    repeat (515) begin
      pcm_ready = 1'b1;
      tick();
      pcm_ready = 1'b0;
      tick();
    end
    force_full = 1'b0;
    send_cmd(8'h04);
    do_read(1'b0, 8'hFF);
    do_read(1'b0, 8'h01);
    send_cmd(8'h03);

    // reset while the high byte is pending
    pcm_data = 16'h4321; pcm_ready = 1'b1;
    tick();
    pcm_ready = 1'b0; force_full = 1'b1;
    chk("rst_lo_en", fifo_wr_en, 1);
    tick();
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("midrst");
    tick();
    rst_n = 1'b1;
    force_full = 1'b0;
    exp_stream.delete();
    tick();
    send_cmd(8'h01);
    do_sample(16'h0F0E, 1'b1);
    drain();

    // randomized traffic against the byte-queue reference
    for (int it = 0; it < 200; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 4 && exp_stream.size() <= 14) begin
        do_sample(16'($urandom), 1'b1);
        repeat ($urandom_range(0, 3)) tick();
      end else if (r < 9) begin
        read_next();
      end else begin
        send_cmd(8'($urandom_range(5, 255)));
        chk("rand_junk_cap", capturing, 1);
        chk("rand_junk_ovf", overflow, 0);
      end
    end
    drain();
    do_read(1'b0, FILL);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pcm_capture_ctrl.md
# pcm_capture_ctrl

Capture/readout controller between the PDM front end (16-bit PCM sample + ready strobe), the 8-bit byte FIFO and the SPI slave. It gates capture on SPI commands and packs each accepted sample into the FIFO as two bytes, low byte first, without ever splitting a pair. On every SPI byte slot it pops one FIFO byte for the SPI transmit register. It counts samples dropped on FIFO overflow and can report that count over SPI.

## Interface

Parameters:
- `FILL_BYTE`, default 8'h00: byte sent when the FIFO is empty.
- `DROP_W`, default 16: drop counter width, saturating; must be ≥ 9.

Ports:
- `clk`, input, 1: system clock; the only clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `pcm_data`, input, 16: PCM sample; valid while `pcm_ready` is high.
- `pcm_ready`, input, 1: one-cycle sample strobe.
- `cmd_byte`, input, 8: byte received from the SPI slave.
- `cmd_valid`, input, 1: one-cycle strobe for `cmd_byte`.
- `spi_busy`, input, 1: SPI slave busy; asynchronous, synchronized internally.
- `tx_byte`, output, 8: next byte for the SPI slave.
- `tx_valid`, output, 1: one-cycle load strobe for `tx_byte`.
- `fifo_wr_en`, output, 1: FIFO write enable.
- `fifo_wr_data`, output, 8: FIFO write data.
- `fifo_full`, input, 1: FIFO full flag.
- `fifo_rd_en`, output, 1: FIFO read enable.
- `fifo_rd_data`, input, 8: FIFO read data; valid the cycle after `fifo_rd_en`.
- `fifo_empty`, input, 1: FIFO empty flag.
- `capturing`, output, 1: capture enabled.
- `overflow`, output, 1: sticky; set when any sample is dropped.

## Operation

Commands (`cmd_valid` high):
- 0x01 START: `capturing`←1; clear drop count and `overflow`.
- 0x02 STOP: `capturing`←0.
- 0x03 CLEAR: clear drop count and `overflow`.
- 0x04 READ_DROP: arm a 2-byte drop-count report.
- Any other value: no effect.

Writer FSM, states W_IDLE and W_HIGH:
- W_IDLE, `pcm_ready` high and registered `capturing` = 1:
  - `fifo_full` = 0: latch `pcm_data` into an internal register, write `pcm_data[7:0]`, go to W_HIGH.
  - `fifo_full` = 1: drop the sample.
- W_HIGH: when `fifo_full` = 0, write the latched `[15:8]` and go to W_IDLE; otherwise stall in W_HIGH.
- Any `pcm_ready` seen in W_HIGH is dropped.
- Drop effect: counter +1, saturating at all-ones; `overflow`←1.
- STOP received in W_HIGH does not abort; the high byte is still written.

Reader FSM, states R_IDLE, R_POP, R_LOAD:
- `spi_busy` passes through a 2-FF synchronizer plus one history flop. A rise is sync=1 with history=0; call the cycle it is seen E.
- R_IDLE on rise, priority order:
  1. Drop report armed: send the counter low byte (zero-extended / truncated to 8 bits), then the high byte `[15:8]` on the next rise; disarm after the second byte. The count is snapshotted at the first byte.
  2. `fifo_empty` = 1 at E: send `FILL_BYTE`.
  3. Otherwise pulse `fifo_rd_en`, go R_POP → R_LOAD, register `fifo_rd_data` into `tx_byte`, return to R_IDLE.
- A rise in R_POP or R_LOAD is ignored; no second pop occurs.
- A FIFO write and read in the same cycle are both issued.

Simultaneous events:
- START and `pcm_ready` in the same cycle: the sample is not captured.
- STOP and `pcm_ready` in the same cycle: the sample is captured, because the registered `capturing` is used.
- CLEAR and a drop in the same cycle: count ends at 0 and `overflow` at 0; CLEAR wins.
- READ_DROP arriving while a report is armed: restarts at the low byte.

## Timing

- Reset (async assert, sync deassert external): all outputs 0; both FSMs idle; drop count 0; report disarmed; sync flops 0.
- Reset mid-operation abandons any half-written pair; the FIFO is reset by the same `rst_n`.
- Write latency: `fifo_wr_en` for the low byte in cycle P+1 (P = `pcm_ready` cycle); high byte in P+2 when not full.
- `fifo_wr_en` is a one-cycle pulse per byte; `fifo_wr_data` holds between writes.
- Read, non-empty: `fifo_rd_en` high in E+1 only; `tx_byte` and `tx_valid` in E+3.
- Read, empty or drop report: `tx_byte` and `tx_valid` in E+1.
- `tx_valid` is always exactly one cycle; `tx_byte` holds until the next load.
- Command effects are visible on `capturing` and `overflow` the cycle after `cmd_valid`.

## Test plan

- START, then samples 0x1234 and 0xBEEF spaced 200 cycles → FIFO writes 0x34, 0x12, 0xEF, 0xBE; four busy rises → `tx_byte` 0x34, 0x12, 0xEF, 0xBE at E+3 each.
- Empty FIFO, busy rise → `tx_byte` = 0x00 with `tx_valid` at E+1; `fifo_rd_en` never asserted.
- Hold `fifo_full` = 1 during 3 samples, then READ_DROP and two rises → bytes 0x03, 0x00; `overflow` = 1; CLEAR → `overflow` 0, next report 0x00, 0x00.
- Low byte written, then `fifo_full` = 1 for 50 cycles with one `pcm_ready` → high byte written after full deasserts; drop count 1; no third byte.
- STOP then `pcm_ready` → no write; START with `pcm_ready` in the same cycle → no write; STOP with `pcm_ready` in the same cycle → pair written.
- Assert `rst_n` low in W_HIGH → all outputs 0 immediately; after release, the next sample is written as a complete pair.
